// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode FIFO of {pc, instr} with valid/ready handshake and one-cycle flush
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [63:0]      mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  // in_ready comes from the registered count only, so a full queue never accepts even while popping
  assign in_ready  = cnt_q != CNT_W'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_pc    = out_valid ? mem_q[rd_q][63:32] : '0;
  assign out_instr = out_valid ? mem_q[rd_q][31:0] : '0;
  assign count     = cnt_q;
  always_comb begin
    rd_d  = flush ? '0 : rd_q + PW'(pop);
    wr_d  = flush ? '0 : wr_q + PW'(push);
    cnt_d = flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {in_pc, in_instr};
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard plus table-driven vectors for the fetch-to-decode queue
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  count;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb [$];

  typedef struct {
    bit          f, iv, ordy;
    logic [31:0] pc;
    int          cnt;
    bit          rdy, ov;
    logic [31:0] opc;
  } vec_t;
  vec_t tv [$];

  if_id_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(logic [31:0] pc);
    return (pc * 32'h0001_0001) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(bit f, bit iv, logic [31:0] pc, bit ordy, int cnt, bit rdy, bit ov, logic [31:0] opc);
    vec_t v;
    v.f = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.cnt = cnt; v.rdy = rdy; v.ov = ov; v.opc = opc;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", n, a, a, e, e);
    end
  endtask

  task automatic post(string n, int cnt, bit rdy, bit ov, logic [31:0] opc);
    chk({n, "_count"}, 32'(count), 32'(cnt));
    chk({n, "_in_ready"}, 32'(in_ready), 32'(rdy));
    chk({n, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({n, "_out_pc"}, out_pc, opc);
    chk({n, "_out_instr"}, out_instr, ov ? ins(opc) : 32'h0);
  endtask

  // drive one cycle; outputs are checked against the scoreboard before the edge
  task automatic cyc(bit f, bit iv, logic [31:0] pc, bit ordy);
    bit ready, acc, pp;
    logic [31:0] hd;
    flush = f; in_valid = iv; in_pc = pc; in_instr = ins(pc); out_ready = ordy;
    #1;
    ready = sb.size() != 4;
    acc   = iv && ready && !f;
    pp    = sb.size() != 0 && ordy && !f;
    hd    = sb.size() != 0 ? sb[0] : 32'h0;
    chk("sb_in_ready", 32'(in_ready), 32'(ready));
    chk("sb_out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("sb_count", 32'(count), 32'(sb.size()));
    chk("sb_out_pc", out_pc, hd);
    chk("sb_out_instr", out_instr, sb.size() != 0 ? ins(hd) : 32'h0);
    @(posedge clk);
    if (f) sb.delete();
    else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(pc);
    end
    #1;
  endtask

  initial begin
    tv.push_back(mk(0, 1,   4, 0, 1, 1, 1,   4));
    tv.push_back(mk(0, 1,   8, 0, 2, 1, 1,   4));
    tv.push_back(mk(0, 1,  12, 0, 3, 1, 1,   4));
    tv.push_back(mk(0, 1,  16, 0, 4, 0, 1,   4));
    tv.push_back(mk(0, 1,  20, 0, 4, 0, 1,   4));
    tv.push_back(mk(0, 1,  20, 1, 3, 1, 1,   8));
    tv.push_back(mk(0, 1,  20, 0, 4, 0, 1,   8));
    tv.push_back(mk(1, 1, 100, 1, 0, 1, 0,   0));
    tv.push_back(mk(0, 1, 200, 0, 1, 1, 1, 200));
    tv.push_back(mk(0, 0,   0, 1, 0, 1, 0,   0));
    tv.push_back(mk(0, 0,   0, 1, 0, 1, 0,   0));
    tv.push_back(mk(0, 0,   0, 1, 0, 1, 0,   0));
    tv.push_back(mk(0, 1, 300, 0, 1, 1, 1, 300));
    tv.push_back(mk(0, 1, 304, 0, 2, 1, 1, 300));
    tv.push_back(mk(0, 0,   0, 0, 2, 1, 1, 300));
    tv.push_back(mk(0, 0,   0, 0, 2, 1, 1, 300));
    tv.push_back(mk(0, 0,   0, 0, 2, 1, 1, 300));
    tv.push_back(mk(0, 0,   0, 1, 1, 1, 1, 304));
    tv.push_back(mk(0, 0,   0, 1, 0, 1, 0,   0));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'd999; in_instr = ins(32'd999); out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    post("reset", 0, 1, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].f, tv[i].iv, tv[i].pc, tv[i].ordy);
      post($sformatf("vec%0d", i), tv[i].cnt, tv[i].rdy, tv[i].ov, tv[i].opc);
    end

    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 32'(4 * (i + 1)), 1);
      post($sformatf("stream%0d", i), 1, 1, 1, 32'(4 * (i + 1)));
    end
    cyc(0, 0, 0, 1);
    post("stream_drain", 0, 1, 0, 0);

    cyc(0, 1, 32'd500, 0);
    cyc(0, 1, 32'd504, 0);
    rst = 1'b1;
    cyc(0, 1, 32'd508, 1);
    rst = 1'b0;
    sb.delete();
    post("mid_reset", 0, 1, 0, 0);
    cyc(0, 1, 32'd600, 0);
    post("after_reset", 1, 1, 1, 600);
    cyc(0, 0, 0, 1);
    post("after_reset_pop", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Fetch-to-decode decoupling queue sitting directly downstream of the instruction fetch stage and feeding the decode stage. It accepts {PC, instruction} pairs from fetch, buffers up to DEPTH entries, and presents them in order to decode under a valid/ready handshake. A branch-taken flush discards all buffered (wrong-path) entries in one cycle. Fetch stalls whenever the queue is full.

## Interface

- DEPTH, 4: number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  branch taken in a later stage; discard all entries.
- in_valid  input  1  fetch presents a valid entry this cycle.
- in_pc  input  32  PC value from fetch (already incremented PC+4).
- in_instr  input  32  instruction word from fetch.
- in_ready  output  1  queue can accept an entry; top level drives fetch Freeze = ~in_ready.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  head PC; 0 when out_valid is low.
- out_instr  output  32  head instruction; 0 (NOP) when out_valid is low.
- out_ready  input  1  decode consumes the head this cycle (low during decode hazard stall).
- count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation

- Storage: DEPTH-entry circular buffer of 64-bit {pc, instr}; read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- push = in_valid & in_ready & ~flush; writes {in_pc, in_instr} at wr_ptr, wr_ptr increments.
- pop = out_valid & out_ready & ~flush; rd_ptr increments.
- count next = count + push − pop; push and pop together leave count unchanged.
- in_ready = (count != DEPTH), from registered count only; never depends on out_ready (no full-cycle bypass).
- out_valid = (count != 0). out_pc/out_instr = storage[rd_ptr] when valid, else 0.
- No empty-queue bypass: an entry pushed in cycle N is visible no earlier than cycle N+1.
- Flush: count, rd_ptr and wr_ptr set to 0 at the clock edge. Flush overrides any push or pop in the same cycle; the in_valid entry that cycle is dropped. Storage contents are not cleared.
- Reset: identical effect to flush. rst has priority over everything.
- A pop and push in the same cycle while full is impossible because in_ready is low; the pop proceeds alone.
- Order preserved strictly FIFO; no entry is duplicated or skipped across pointer wrap.

## Timing

- After reset: count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1.
- Push-to-output latency: 1 cycle (push at edge N, out_valid high after edge N).
- Sustained throughput: 1 entry/cycle when both sides ready and 0 < count < DEPTH.
- Full: after DEPTH pushes with no pops, in_ready=0 from the next cycle; it returns to 1 the cycle after the first pop.
- Flush asserted in cycle N: out_valid=0 and in_ready=1 after edge N. An entry presented in cycle N+1 is accepted normally.
- Handshake: fetch holds in_pc/in_instr while in_ready is low (enforced by Freeze). The queue never accepts an entry in a cycle where in_ready is low.

## Test plan

- Reset: assert rst 2 cycles with in_valid=1 -> count=0, out_valid=0, out_instr=0, in_ready=1. The entry presented during reset is not stored.
- Fill/backpressure: DEPTH=4, out_ready=0, push pc=4,8,12,16 -> count=4, in_ready=0. The 5th entry (pc=20) is held by the bench. Raise out_ready for 1 cycle -> pc=4 pops, in_ready=1 next cycle, pc=20 is accepted.
- Streaming/wrap: in_valid=out_ready=1 for 12 cycles, pc=4..48 -> out_pc sequence 4..48 in order with 1-cycle latency. count stays at 1. Pointers wrap 3 times with no loss.
- Flush when full: queue holds 4 entries, flush=1 with in_valid=1 (pc=100) and out_ready=1 -> next cycle count=0, out_valid=0. pc=100 is not stored. Next push pc=200 appears as out_pc=200.
- Decode stall: count=2, out_ready=0 for 3 cycles -> out_pc/out_instr stable on the head entry and count stays 2. Release -> entries emerge in order.
- Empty with out_ready=1: no push -> out_valid=0, out_instr=0, count never underflows (stays 0).
